// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants and types.
// Used by the register file and its pending-write scoreboard.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;
    localparam int NUM_REGS   = 32;
    localparam int PEND_WIDTH = 2;

    typedef logic [ADDR_WIDTH-1:0] reg_addr_t;
    typedef logic [DATA_WIDTH-1:0] word_t;

    localparam reg_addr_t REG_ZERO = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register pending-write counters and RAW hazard detection.
// Option: WB_BYPASS_EN lets the last retiring writer clear its stall early.
module reg_scoreboard #(
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PEND_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_dest,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [ADDR_WIDTH-1:0] issue_dest,
    input  logic                  flush,
    input  logic [ADDR_WIDTH-1:0] rs_addr,
    input  logic [ADDR_WIDTH-1:0] rt_addr,
    output logic                  hazard_stall,
    output logic                  pend_overflow
);
    import mips_pkg::*;

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;
    localparam logic [PEND_WIDTH-1:0] PEND_ONE = PEND_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [PEND_WIDTH-1:0] pend      [NUM_REGS];
    logic [PEND_WIDTH-1:0] pend_next [NUM_REGS];
    logic [NUM_REGS-1:0]   inc_vec;
    logic [NUM_REGS-1:0]   dec_vec;
    logic                  retire;
    logic                  issue_ok;
    logic                  same_reg;

    function automatic logic src_busy(input logic [ADDR_WIDTH-1:0] r);
        logic busy;
        busy = (r != ZERO_IDX) && (pend[r] != '0);
`ifdef WB_BYPASS_EN
        if (retire && wb_dest == r && pend[r] == PEND_ONE)
            busy = 1'b0;
`endif
        return busy;
    endfunction

    // Stall decode when either source still has a writer in flight
    always_comb begin
        hazard_stall = issue_valid && (src_busy(rs_addr) || src_busy(rt_addr));
    end

    // Qualify issue and retire events into one-hot per-register strobes
    always_comb begin
        retire   = wb_reg_write && (wb_dest != ZERO_IDX);
        issue_ok = issue_valid && issue_writes && !hazard_stall
                   && (issue_dest != ZERO_IDX) && !flush;
        same_reg = retire && (wb_dest == issue_dest);
        inc_vec  = issue_ok ? (NUM_REGS'(1) << issue_dest) : '0;
        dec_vec  = retire ? (NUM_REGS'(1) << wb_dest) : '0;
    end

    // Next counter values: flush clears, simultaneous inc/dec cancels
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            pend_next[r] = pend[r];
            if (flush)
                pend_next[r] = '0;
            else if (inc_vec[r] && !dec_vec[r] && pend[r] != PEND_MAX)
                pend_next[r] = pend[r] + PEND_ONE;
            else if (dec_vec[r] && !inc_vec[r] && pend[r] != '0)
                pend_next[r] = pend[r] - PEND_ONE;
        end
    end

    // Counter state and sticky overflow flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                pend[r] <= '0;
            pend_overflow <= 1'b0;
        end else begin
            pend <= pend_next;
            if (issue_ok && !same_reg && pend[issue_dest] == PEND_MAX)
                pend_overflow <= 1'b1;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with a RAW-hazard scoreboard.
// Option: WB_BYPASS_EN enables write-through reads of the retiring value.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REGS   = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int PEND_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_dest,
    input  logic [DATA_WIDTH-1:0] wb_data,
    input  logic [ADDR_WIDTH-1:0] id_rs_addr,
    input  logic [ADDR_WIDTH-1:0] id_rt_addr,
    output logic [DATA_WIDTH-1:0] id_rs_data,
    output logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic                  issue_valid,
    input  logic                  issue_writes,
    input  logic [ADDR_WIDTH-1:0] issue_dest,
    input  logic                  flush,
    output logic                  hazard_stall,
    output logic                  pend_overflow
);
    import mips_pkg::*;

    localparam logic [ADDR_WIDTH-1:0] ZERO_IDX = ADDR_WIDTH'(REG_ZERO);

    logic [DATA_WIDTH-1:0] regs [NUM_REGS];
    logic                  retire;

    assign retire = wb_reg_write && (wb_dest != ZERO_IDX);

    // Register array; register 0 is never written
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NUM_REGS; r++)
                regs[r] <= '0;
        end else if (retire) begin
            regs[wb_dest] <= wb_data;
        end
    end

    // Combinational read ports with optional write-through
    always_comb begin
        id_rs_data = (id_rs_addr == ZERO_IDX) ? '0 : regs[id_rs_addr];
        id_rt_data = (id_rt_addr == ZERO_IDX) ? '0 : regs[id_rt_addr];
`ifdef WB_BYPASS_EN
        if (!reset && retire && wb_dest == id_rs_addr)
            id_rs_data = wb_data;
        if (!reset && retire && wb_dest == id_rt_addr)
            id_rt_data = wb_data;
`endif
    end

    reg_scoreboard #(
        .NUM_REGS   (NUM_REGS),
        .ADDR_WIDTH (ADDR_WIDTH),
        .PEND_WIDTH (PEND_WIDTH)
    ) u_sb (
        .clk           (clk),
        .reset         (reset),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_dest    (issue_dest),
        .flush         (flush),
        .rs_addr       (id_rs_addr),
        .rt_addr       (id_rt_addr),
        .hazard_stall  (hazard_stall),
        .pend_overflow (pend_overflow)
    );

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Scoreboard-style bench for reg_file_scoreboard.
// Expectations follow WB_BYPASS_EN when it is defined.
module tb_reg_file_scoreboard;

`ifdef WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        wb_reg_write;
    logic [4:0]  wb_dest;
    logic [31:0] wb_data;
    logic [4:0]  id_rs_addr;
    logic [4:0]  id_rt_addr;
    logic [31:0] id_rs_data;
    logic [31:0] id_rt_data;
    logic        issue_valid;
    logic        issue_writes;
    logic [4:0]  issue_dest;
    logic        flush;
    logic        hazard_stall;
    logic        pend_overflow;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       nm;
        logic [3:0]  m;
        logic [31:0] rs;
        logic [31:0] rt;
        logic        st;
        logic        ov;
    } exp_t;

    exp_t q[$];
    exp_t e;

    always #5 clk = ~clk;

    reg_file_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .wb_reg_write  (wb_reg_write),
        .wb_dest       (wb_dest),
        .wb_data       (wb_data),
        .id_rs_addr    (id_rs_addr),
        .id_rt_addr    (id_rt_addr),
        .id_rs_data    (id_rs_data),
        .id_rt_data    (id_rt_data),
        .issue_valid   (issue_valid),
        .issue_writes  (issue_writes),
        .issue_dest    (issue_dest),
        .flush         (flush),
        .hazard_stall  (hazard_stall),
        .pend_overflow (pend_overflow)
    );

    task automatic cmp(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: compare the pending expectation once per cycle
    always @(negedge clk) begin
        if (q.size() != 0) begin
            e = q.pop_front();
            if (e.m[3]) cmp({e.nm, ".rs"}, id_rs_data, e.rs);
            if (e.m[2]) cmp({e.nm, ".rt"}, id_rt_data, e.rt);
            if (e.m[1]) cmp({e.nm, ".stall"}, 32'(hazard_stall), 32'(e.st));
            if (e.m[0]) cmp({e.nm, ".ovf"}, 32'(pend_overflow), 32'(e.ov));
        end
    end

    task automatic cyc(input logic wr, input logic [4:0] dst,
                       input logic [31:0] dat, input logic [4:0] rs,
                       input logic [4:0] rt, input logic iv, input logic iw,
                       input logic [4:0] idst, input logic fl);
        @(posedge clk);
        #1;
        wb_reg_write = wr;
        wb_dest      = dst;
        wb_data      = dat;
        id_rs_addr   = rs;
        id_rt_addr   = rt;
        issue_valid  = iv;
        issue_writes = iw;
        issue_dest   = idst;
        flush        = fl;
    endtask

    task automatic ex(input string nm, input logic [3:0] m,
                      input logic [31:0] rs, input logic [31:0] rt,
                      input logic st, input logic ov);
        exp_t x;
        x.nm = nm; x.m = m; x.rs = rs; x.rt = rt; x.st = st; x.ov = ov;
        q.push_back(x);
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        wb_reg_write = 0; wb_dest = 0; wb_data = 0;
        id_rs_addr = 0; id_rt_addr = 0;
        issue_valid = 0; issue_writes = 0; issue_dest = 0; flush = 0;

        idle();
        ex("reset", 4'hF, 0, 0, 0, 0);
        idle();
        reset = 1'b0;

        // write reg 5, read back; reg 0 discards writes
        cyc(1, 5, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0);
        ex("wr5_same", 4'h8, BYP ? 32'hDEADBEEF : 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 5, 0, 0, 0, 0, 0);
        ex("rd5", 4'hD, 32'hDEADBEEF, 0, 0, 0);
        cyc(1, 0, 32'h1234, 0, 5, 0, 0, 0, 0);
        ex("wr0", 4'hC, 0, 32'hDEADBEEF, 0, 0);
        cyc(0, 0, 0, 0, 5, 0, 0, 0, 0);
        ex("rd0", 4'hC, 0, 32'hDEADBEEF, 0, 0);

        // mid-run async reset clears regs and stall before any edge
        cyc(0, 0, 0, 0, 0, 1, 1, 8, 0);
        ex("pre_issue8", 4'h2, 0, 0, 0, 0);
        cyc(0, 0, 0, 5, 8, 1, 0, 0, 0);
        ex("pre_reset", 4'hA, 32'hDEADBEEF, 0, 1, 0);
        cyc(0, 0, 0, 5, 8, 1, 0, 0, 0);
        reset = 1'b1;
        ex("mid_reset", 4'hF, 0, 0, 0, 0);
        idle();
        reset = 1'b0;

        // RAW on reg 8 until retire
        cyc(0, 0, 0, 0, 0, 1, 1, 8, 0);
        ex("t3_issue", 4'h2, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 8, 1, 0, 0, 0);
        ex("t3_stall_a", 4'h2, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 8, 1, 0, 0, 0);
        ex("t3_stall_b", 4'h2, 0, 0, 1, 0);
        cyc(1, 8, 32'hA5A50008, 0, 8, 1, 0, 0, 0);
        ex("t3_retire", 4'h6, 0, BYP ? 32'hA5A50008 : 32'h0, !BYP, 0);
        cyc(0, 0, 0, 0, 8, 1, 0, 0, 0);
        ex("t3_after", 4'h6, 0, 32'hA5A50008, 0, 0);

        // issue+retire same reg same cycle keeps pend[3]=1
        cyc(0, 0, 0, 0, 0, 1, 1, 3, 0);
        ex("t4_issue1", 4'h2, 0, 0, 0, 0);
        cyc(1, 3, 32'h33, 0, 0, 1, 1, 3, 0);
        ex("t4_issue2", 4'h2, 0, 0, 0, 0);
        cyc(0, 0, 0, 3, 0, 1, 0, 0, 0);
        ex("t4_persist_a", 4'hA, 32'h33, 0, 1, 0);
        cyc(0, 0, 0, 3, 0, 1, 0, 0, 0);
        ex("t4_persist_b", 4'h2, 0, 0, 1, 0);
        cyc(1, 3, 32'h34, 3, 0, 1, 0, 0, 0);
        ex("t4_retire", 4'hA, BYP ? 32'h34 : 32'h33, 0, !BYP, 0);
        cyc(0, 0, 0, 3, 0, 1, 0, 0, 0);
        ex("t4_after", 4'hA, 32'h34, 0, 0, 0);

        // saturate pend[9], then flush with same-cycle retire of reg 11
        for (int i = 0; i < 4; i++) begin
            cyc(0, 0, 0, 0, 0, 1, 1, 9, 0);
            ex("t5_issue", 4'h3, 0, 0, 0, 0);
        end
        cyc(0, 0, 0, 9, 0, 1, 0, 0, 0);
        ex("t5_ovf", 4'h3, 0, 0, 1, 1);
        cyc(1, 11, 32'hB0B0, 0, 0, 1, 1, 9, 1);
        ex("t5_flush", 4'h1, 0, 0, 0, 1);
        cyc(0, 0, 0, 9, 11, 1, 0, 0, 0);
        ex("t5_cleared", 4'h7, 0, 32'hB0B0, 0, 1);

        // retire with pend[10]=0: no underflow, array written
        cyc(1, 10, 32'h1010, 10, 0, 1, 0, 0, 0);
        ex("t6_retire", 4'hA, BYP ? 32'h1010 : 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 10, 0, 1, 0, 0, 0);
        ex("t6_read", 4'hA, 32'h1010, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 1, 1, 10, 0);
        ex("t6_issue", 4'h2, 0, 0, 0, 0);
        cyc(0, 0, 0, 10, 0, 1, 0, 0, 0);
        ex("t6_busy", 4'h2, 0, 0, 1, 0);
        cyc(1, 10, 32'h1011, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 10, 0, 1, 0, 0, 0);
        ex("t6_free", 4'hA, 32'h1011, 0, 0, 0);

        idle();
        @(negedge clk);
        #1;
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d want 0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
